// File: rtl/bb_rz_pulse_decoder.sv
// Return-to-zero baseband pulse decoder: measures the high time in each bit period
// after locking on a rising edge, and flags glitches and pulses that never return low.
module bb_rz_pulse_decoder #(
    parameter int RZ_PERIOD = 10,
    parameter int MIN_WIDTH = 2,
    parameter int MAX_ZEROS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       pulse_in,
    output logic       bit_out,
    output logic       bit_valid,
    output logic [3:0] pw_meas,
    output logic       locked,
    output logic       err_glitch,
    output logic       err_rz
);

    // state  | meaning
    // HUNT   | waiting for a rising edge of s_pulse to start a period
    // LOCKED | counting bit periods, deciding one bit per period
    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam logic [3:0] LAST_CYC = 4'(RZ_PERIOD - 1);
    localparam logic [3:0] MIN_W    = 4'(MIN_WIDTH);
    localparam logic [3:0] MAX_Z    = 4'(MAX_ZEROS);

    logic [0:0] state;
    logic       sync_1;
    logic       s_pulse;
    logic       s_pulse_d;
    logic [3:0] per_cnt;
    logic [3:0] high_cnt;
    logic [3:0] zero_run;

    logic [3:0] high_total;
    logic [3:0] zero_next;
    logic       is_one;
    logic       rising;

    // high_cnt holds the count of earlier cycles in the period; high_total adds the current one
    assign high_total = (high_cnt == 4'd15) ? 4'd15 : high_cnt + {3'b000, s_pulse};
    assign is_one     = (high_total >= MIN_W);
    assign zero_next  = (zero_run == 4'd15) ? 4'd15 : zero_run + 4'd1;
    assign rising     = s_pulse & ~s_pulse_d;
    assign locked     = (state == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            sync_1     <= 1'b0;
            s_pulse    <= 1'b0;
            s_pulse_d  <= 1'b0;
            per_cnt    <= 4'd0;
            high_cnt   <= 4'd0;
            zero_run   <= 4'd0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            pw_meas    <= 4'd0;
            err_glitch <= 1'b0;
            err_rz     <= 1'b0;
        end else begin
            sync_1     <= pulse_in;
            s_pulse    <= sync_1;
            s_pulse_d  <= s_pulse;
            bit_valid  <= 1'b0;
            err_glitch <= 1'b0;
            err_rz     <= 1'b0;

            if (!en) begin
                state    <= HUNT;
                per_cnt  <= 4'd0;
                high_cnt <= 4'd0;
                zero_run <= 4'd0;
            end else begin
                case (state)
                    HUNT: begin
                        if (rising) begin
                            // the edge cycle itself is cycle 0 and already counts as high
                            state    <= LOCKED;
                            per_cnt  <= 4'd1;
                            high_cnt <= 4'd1;
                            zero_run <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (per_cnt == LAST_CYC) begin
                            per_cnt    <= 4'd0;
                            high_cnt   <= 4'd0;
                            bit_valid  <= 1'b1;
                            bit_out    <= is_one;
                            pw_meas    <= high_total;
                            err_glitch <= (high_total != 4'd0) && !is_one;
                            err_rz     <= s_pulse;
                            zero_run   <= is_one ? 4'd0 : zero_next;
                            if (s_pulse || (!is_one && (zero_next >= MAX_Z))) begin
                                state    <= HUNT;
                                zero_run <= 4'd0;
                            end
                        end else begin
                            per_cnt  <= per_cnt + 4'd1;
                            high_cnt <= high_total;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule
